// File: rtl/mem_sram_ctrl_if.sv
// Bundle between the EXE/MEM pipeline register, the SRAM controller and the external SRAM.
// The slave modport is the controller; master is the pipeline/SRAM side that drives requests.
interface mem_sram_ctrl_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       ALU_res;
  logic [31:0]       ST_val;
  logic [31:0]       read_data;
  logic              ready;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_WE_N;
  logic [15:0]       SRAM_DQ_O;
  logic              SRAM_DQ_OE;
  logic [15:0]       SRAM_DQ_I;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_res, ST_val, SRAM_DQ_I,
    output read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_O, SRAM_DQ_OE
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_res, ST_val, SRAM_DQ_I,
    input  read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_O, SRAM_DQ_OE
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// Memory-stage SRAM controller: splits each 32-bit load/store into two timed 16-bit accesses
// (low half first) and holds ready low until the access finishes.
module mem_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned ADDR_W      = 18
) (
  input logic                 clk,
  input logic                 rst,
  mem_sram_ctrl_if.slave      bus
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              req;
  logic              is_wr;
  logic              last;
  logic [ADDR_W-2:0] word;
  logic              ready;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we_n;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe;

  // Address bits above the SRAM size and the byte offset are intentionally dropped.
  logic unused_alu_bits;
  assign unused_alu_bits = ^{bus.ALU_res[31:ADDR_W+1], bus.ALU_res[1:0]};

  assign req   = bus.MEM_R_EN | bus.MEM_W_EN;
  assign is_wr = bus.MEM_W_EN;
  assign last  = (cnt_q == CntLast);
  assign word  = bus.ALU_res[ADDR_W:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    ready      = 1'b0;
    sram_addr  = '0;
    sram_we_n  = 1'b1;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = ~req;
        if (req) begin
          state_d = StLow;
          cnt_d   = '0;
        end
      end
      StLow: begin
        sram_addr = {word, 1'b0};
        if (is_wr) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
          sram_dq_o  = bus.ST_val[15:0];
        end
        if (last) begin
          state_d = StHigh;
          cnt_d   = '0;
          if (!is_wr) rdata_d[15:0] = bus.SRAM_DQ_I;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHigh: begin
        sram_addr = {word, 1'b1};
        if (is_wr) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
          sram_dq_o  = bus.ST_val[31:16];
        end
        if (last) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!is_wr) rdata_d[31:16] = bus.SRAM_DQ_I;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready      = ready;
  assign bus.read_data  = rdata_q;
  assign bus.SRAM_ADDR  = sram_addr;
  assign bus.SRAM_WE_N  = sram_we_n;
  assign bus.SRAM_DQ_O  = sram_dq_o;
  assign bus.SRAM_DQ_OE = sram_dq_oe;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl at WAIT_CYCLES=3 against a simple synchronous-write SRAM model.
module tb_mem_sram_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [15:0] mem [0:1023];

  mem_sram_ctrl_if #(.ADDR_W(18)) bus ();

  mem_sram_ctrl #(
    .WAIT_CYCLES(3),
    .ADDR_W     (18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!bus.SRAM_WE_N) mem[bus.SRAM_ADDR[9:0]] <= bus.SRAM_DQ_O;
  end
  assign bus.SRAM_DQ_I = mem[bus.SRAM_ADDR[9:0]];

  task automatic test_reset();
    logic [69:0] got, exp;
    rst = 1'b1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    bus.ALU_res  = 32'h0;
    bus.ST_val   = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = {bus.read_data, bus.ready, bus.SRAM_WE_N, bus.SRAM_DQ_OE, bus.SRAM_ADDR, bus.SRAM_DQ_O};
      exp = {32'h0, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0};
      n_checks++;
      if (got !== exp) $display("FAIL reset_idle cyc=%0d: got %h want %h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_write();
    logic [37:0] got, exp;
    @(posedge clk);
    #1;
    bus.MEM_W_EN = 1'b1;
    bus.ALU_res  = 32'h0000_0010;
    bus.ST_val   = 32'hDEAD_BEEF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      got = {bus.ready, bus.SRAM_WE_N, bus.SRAM_DQ_OE, bus.SRAM_ADDR, bus.SRAM_DQ_O};
      if (c == 0)     exp = {1'b0, 1'b1, 1'b0, 18'd0, 16'h0};
      else if (c < 4) exp = {1'b0, 1'b0, 1'b1, 18'd8, 16'hBEEF};
      else if (c < 7) exp = {1'b0, 1'b0, 1'b1, 18'd9, 16'hDEAD};
      else            exp = {1'b1, 1'b1, 1'b0, 18'd0, 16'h0};
      n_checks++;
      if (got !== exp) $display("FAIL write_timing cyc=%0d: got %h want %h", c, got, exp);
      else n_pass++;
    end
    @(posedge clk);
    #1 bus.MEM_W_EN = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem[8], mem[9]} !== 32'hBEEF_DEAD)
      $display("FAIL write_sram_contents: got %h want %h", {mem[8], mem[9]}, 32'hBEEF_DEAD);
    else n_pass++;
  endtask

  task automatic test_read();
    logic [2:0] got, exp;
    @(posedge clk);
    #1;
    bus.MEM_R_EN = 1'b1;
    bus.ALU_res  = 32'h0000_0010;
    bus.ST_val   = 32'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      got = {bus.ready, bus.SRAM_WE_N, bus.SRAM_DQ_OE};
      exp = {(c == 7), 1'b1, 1'b0};
      n_checks++;
      if (got !== exp) $display("FAIL read_strobes cyc=%0d: got %b want %b", c, got, exp);
      else n_pass++;
      if (c == 4) begin
        n_checks++;
        if (bus.read_data !== 32'h0000_BEEF)
          $display("FAIL read_low_half: got %h want %h", bus.read_data, 32'h0000_BEEF);
        else n_pass++;
      end
      if (c == 7) begin
        n_checks++;
        if (bus.read_data !== 32'hDEAD_BEEF)
          $display("FAIL read_done: got %h want %h", bus.read_data, 32'hDEAD_BEEF);
        else n_pass++;
      end
    end
    @(posedge clk);
    #1 bus.MEM_R_EN = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.ready, bus.read_data} !== {1'b1, 32'hDEAD_BEEF})
      $display("FAIL read_hold: got %h want %h", {bus.ready, bus.read_data}, {1'b1, 32'hDEAD_BEEF});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [34:0] got, exp;
    @(posedge clk);
    #1;
    bus.MEM_W_EN = 1'b1;
    bus.ALU_res  = 32'h0000_0020;
    bus.ST_val   = 32'h1234_5678;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1 || c == 4 || c == 7) begin
        got = {bus.ready, bus.SRAM_ADDR, bus.SRAM_DQ_O};
        if (c == 1)      exp = {1'b0, 18'd16, 16'h5678};
        else if (c == 4) exp = {1'b0, 18'd17, 16'h1234};
        else             exp = {1'b1, 18'd0, 16'h0};
        n_checks++;
        if (got !== exp) $display("FAIL b2b_store cyc=%0d: got %h want %h", c, got, exp);
        else n_pass++;
      end
    end
    // Request stays asserted: switch straight from store to load.
    @(posedge clk);
    #1;
    bus.MEM_W_EN = 1'b0;
    bus.MEM_R_EN = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.ready, bus.SRAM_WE_N, bus.SRAM_ADDR} !== {1'b0, 1'b1, 18'd0})
      $display("FAIL b2b_idle_gap: got %h want %h",
               {bus.ready, bus.SRAM_WE_N, bus.SRAM_ADDR}, {1'b0, 1'b1, 18'd0});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.ready, bus.SRAM_WE_N, bus.SRAM_ADDR} !== {1'b0, 1'b1, 18'd16})
      $display("FAIL b2b_load_low: got %h want %h",
               {bus.ready, bus.SRAM_WE_N, bus.SRAM_ADDR}, {1'b0, 1'b1, 18'd16});
    else n_pass++;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({bus.ready, bus.read_data} !== {1'b1, 32'h1234_5678})
      $display("FAIL b2b_load_data: got %h want %h",
               {bus.ready, bus.read_data}, {1'b1, 32'h1234_5678});
    else n_pass++;
    @(posedge clk);
    #1 bus.MEM_R_EN = 1'b0;
  endtask

  task automatic test_both_wrap();
    logic [35:0] got, exp;
    @(posedge clk);
    #1;
    bus.MEM_R_EN = 1'b1;
    bus.MEM_W_EN = 1'b1;
    bus.ALU_res  = 32'h0008_0004;
    bus.ST_val   = 32'hCAFE_F00D;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1 || c == 4) begin
        got = {bus.SRAM_WE_N, bus.SRAM_DQ_OE, bus.SRAM_ADDR, bus.SRAM_DQ_O};
        exp = (c == 1) ? {1'b0, 1'b1, 18'd2, 16'hF00D} : {1'b0, 1'b1, 18'd3, 16'hCAFE};
        n_checks++;
        if (got !== exp) $display("FAIL both_wrap cyc=%0d: got %h want %h", c, got, exp);
        else n_pass++;
      end
      if (c == 7) begin
        n_checks++;
        if ({bus.ready, bus.read_data} !== {1'b1, 32'h1234_5678})
          $display("FAIL both_rdata_kept: got %h want %h",
                   {bus.ready, bus.read_data}, {1'b1, 32'h1234_5678});
        else n_pass++;
      end
    end
    @(posedge clk);
    #1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem[2], mem[3]} !== 32'hF00D_CAFE)
      $display("FAIL both_sram_contents: got %h want %h", {mem[2], mem[3]}, 32'hF00D_CAFE);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    bus.MEM_R_EN = 1'b1;
    bus.ALU_res  = 32'h0000_0010;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.read_data !== 32'h1234_BEEF)
      $display("FAIL mid_low_half: got %h want %h", bus.read_data, 32'h1234_BEEF);
    else n_pass++;
    // Second HIGH cycle: assert reset with the request still held.
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b0) $display("FAIL mid_before_rst: got %b want %b", bus.ready, 1'b0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.ready, bus.SRAM_WE_N, bus.SRAM_ADDR, bus.read_data} !== {1'b0, 1'b1, 18'd0, 32'h0})
      $display("FAIL mid_reset_held: got %h want %h",
               {bus.ready, bus.SRAM_WE_N, bus.SRAM_ADDR, bus.read_data},
               {1'b0, 1'b1, 18'd0, 32'h0});
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.MEM_R_EN = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.ready, bus.SRAM_WE_N, bus.read_data} !== {1'b1, 1'b1, 32'h0})
      $display("FAIL mid_reset_idle: got %h want %h",
               {bus.ready, bus.SRAM_WE_N, bus.read_data}, {1'b1, 1'b1, 32'h0});
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_both_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
